// File: rtl/rr_pkg.sv
// Shared definitions for the virtual-channel round-robin scheduler.
// Provides the data width, source count, FSM state encoding and the bit
// positions of the destination field inside a data word.
package rr_pkg;

    localparam int unsigned DATA_W   = 10;
    localparam int unsigned NUM_SRC  = 4;
    localparam int unsigned SRC_W    = 2;
    localparam int unsigned DEST_MSB = 9;
    localparam int unsigned DEST_LSB = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SERVE = 2'b01,
        PAUSE = 2'b10
    } state_t;

endpackage : rr_pkg

// File: rtl/rr_priority_pick.sv
// Rotating first-one finder.
// Ports:
//   req     - request vector, bit i set when source i has data
//   ptr     - index where the search starts (wraps modulo NUM_SRC)
//   idx     - first requesting source at or after ptr
//   any_req - at least one request bit is set
module rr_priority_pick
    import rr_pkg::*;
(
    input  logic [NUM_SRC-1:0] req,
    input  logic [SRC_W-1:0]   ptr,
    output logic [SRC_W-1:0]   idx,
    output logic               any_req
);

    logic [SRC_W-1:0] cand;

    // Walk offsets from far to near so the nearest requester wins.
    always_comb begin
        idx     = '0;
        cand    = '0;
        any_req = |req;
        for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
            cand = SRC_W'(ptr + SRC_W'(i));
            if (req[cand]) begin
                idx = cand;
            end
        end
    end

endmodule : rr_priority_pick

// File: rtl/rr_scheduler.sv
// Round-robin scheduler for the four source FIFOs of the VC datapath.
// Pops at most one word per cycle from the granted source, forwards it
// registered to the destination demux and lets each grant run for up to
// QUANTUM words before rotating through IDLE.
// Ports:
//   clk, reset         - rising-edge clock, synchronous active-low reset
//   fifo_empty         - per-source empty flags
//   fifo_data_0..3     - head word of each source
//   out_almost_full    - downstream backpressure, blocks pops the same cycle
//   pop                - combinational one-hot-or-zero dequeue strobe
//   data_out/valid_out - registered popped word and its valid flag
//   select             - registered destination field of data_out
//   grant_id           - currently granted source
module rr_scheduler
    import rr_pkg::*;
#(
    parameter int unsigned DATA_W  = rr_pkg::DATA_W,
    parameter int unsigned QUANTUM = 4,
    parameter int unsigned CNT_W   = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        fifo_empty,
    input  logic [DATA_W-1:0] fifo_data_0,
    input  logic [DATA_W-1:0] fifo_data_1,
    input  logic [DATA_W-1:0] fifo_data_2,
    input  logic [DATA_W-1:0] fifo_data_3,
    input  logic              out_almost_full,
    output logic [3:0]        pop,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic [1:0]        select,
    output logic [1:0]        grant_id
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(QUANTUM - 1);

    state_t            state;
    logic [SRC_W-1:0]  ptr;
    logic [CNT_W-1:0]  cnt;

    logic [SRC_W-1:0]  pick_idx;
    logic              pick_any;
    logic [DATA_W-1:0] head;
    logic              pop_g;
    logic [SRC_W-1:0]  next_ptr;

    rr_priority_pick u_pick (
        .req     (~fifo_empty),
        .ptr     (ptr),
        .idx     (pick_idx),
        .any_req (pick_any)
    );

    // Head word of the granted source.
    always_comb begin
        head = '0;
        case (grant_id)
            2'd0:    head = fifo_data_0;
            2'd1:    head = fifo_data_1;
            2'd2:    head = fifo_data_2;
            default: head = fifo_data_3;
        endcase
    end

    // Pop strobe is combinational so backpressure blocks the pop this cycle.
    assign pop_g    = reset && (state == SERVE) && !fifo_empty[grant_id] && !out_almost_full;
    assign pop      = pop_g ? (4'b0001 << grant_id) : 4'b0000;
    assign next_ptr = SRC_W'(grant_id + 2'd1);

    // Scheduler FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            ptr       <= '0;
            cnt       <= '0;
            grant_id  <= '0;
            data_out  <= '0;
            select    <= '0;
            valid_out <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (!out_almost_full && pick_any) begin
                        grant_id <= pick_idx;
                        cnt      <= '0;
                        state    <= SERVE;
                    end
                end
                SERVE: begin
                    if (pop_g) begin
                        data_out  <= head;
                        select    <= head[DEST_MSB:DEST_LSB];
                        valid_out <= 1'b1;
                        cnt       <= CNT_W'(cnt + 1'b1);
                        if (cnt == LAST_CNT) begin
                            ptr   <= next_ptr;
                            state <= IDLE;
                        end
                    end else if (fifo_empty[grant_id]) begin
                        // Source ran dry before its quantum expired.
                        ptr   <= next_ptr;
                        state <= IDLE;
                    end else begin
                        state <= PAUSE;
                    end
                end
                PAUSE: begin
                    if (!out_almost_full) begin
                        state <= SERVE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule : rr_scheduler

// File: tb/tb_rr_scheduler.sv
// Directed bench for rr_scheduler: FIFO models feed the DUT, expected
// source order and words are queued at stimulus time and compared as the
// DUT pops and delivers them.
module tb_rr_scheduler;
    import rr_pkg::*;

    logic       clk;
    logic       reset;
    logic [3:0] fifo_empty;
    logic [9:0] fifo_data_0, fifo_data_1, fifo_data_2, fifo_data_3;
    logic       out_almost_full;
    logic [3:0] pop;
    logic [9:0] data_out;
    logic       valid_out;
    logic [1:0] select;
    logic [1:0] grant_id;

    int checks = 0;
    int errors = 0;

    logic [9:0] fq [4][$];
    int         src_q [$];
    logic [9:0] exp_q [$];

    logic [3:0] last_p;
    logic [9:0] last_data;
    int         cyc = 0;
    int         last_src = -1;
    int         last_pop_cyc = 0;

    rr_scheduler dut (
        .clk             (clk),
        .reset           (reset),
        .fifo_empty      (fifo_empty),
        .fifo_data_0     (fifo_data_0),
        .fifo_data_1     (fifo_data_1),
        .fifo_data_2     (fifo_data_2),
        .fifo_data_3     (fifo_data_3),
        .out_almost_full (out_almost_full),
        .pop             (pop),
        .data_out        (data_out),
        .valid_out       (valid_out),
        .select          (select),
        .grant_id        (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, observed cyc=%0d required finish", cyc);
        $fatal(1, "timeout");
    end

    task automatic drive_ports();
        for (int i = 0; i < 4; i++) fifo_empty[i] = (fq[i].size() == 0);
        fifo_data_0 = (fq[0].size() != 0) ? fq[0][0] : 10'h000;
        fifo_data_1 = (fq[1].size() != 0) ? fq[1][0] : 10'h000;
        fifo_data_2 = (fq[2].size() != 0) ? fq[2][0] : 10'h000;
        fifo_data_3 = (fq[3].size() != 0) ? fq[3][0] : 10'h000;
    endtask

    task automatic load(input int s, input logic [9:0] d);
        fq[s].push_back(d);
        drive_ports();
    endtask

    task automatic expect_w(input int s, input logic [9:0] d);
        src_q.push_back(s);
        exp_q.push_back(d);
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock cycle: sample pop mid-cycle, apply it to the FIFO models,
    // then check the registered outputs just after the edge.
    task automatic tick();
        logic [3:0] p;
        logic       rst_at;
        logic [9:0] ed;
        int         s;
        int         es;
        #1;
        p      = pop;
        rst_at = reset;
        last_p = p;
        s      = -1;
        for (int i = 0; i < 4; i++) if (p[i]) s = i;
        if (p != 4'b0000) begin
            checks++;
            assert ($onehot(p)) else begin
                errors++;
                $error("FAIL pop_onehot observed=%b expected=one-hot", p);
            end
            checks++;
            assert (fq[s].size() != 0) else begin
                errors++;
                $error("FAIL pop_empty observed=pop[%0d] expected=no pop of empty source", s);
            end
            if (src_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL pop_unexpected observed=src %0d expected=no pop", s);
            end else begin
                es = src_q.pop_front();
                check_int("pop_src", s, es);
            end
            if (last_src >= 0 && last_src != s) begin
                checks++;
                assert (cyc - last_pop_cyc >= 2) else begin
                    errors++;
                    $error("FAIL rotate_bubble observed=gap %0d expected>=2", cyc - last_pop_cyc);
                end
            end
            last_src     = s;
            last_pop_cyc = cyc;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (s >= 0 && fq[s].size() != 0) void'(fq[s].pop_front());
        drive_ports();
        if (!rst_at) begin
            last_data = 10'h000;
            checks++;
            assert (valid_out === 1'b0 && data_out === 10'h000 && select === 2'b00) else begin
                errors++;
                $error("FAIL reset_outputs observed=v%b d%h s%b expected=v0 d000 s00",
                       valid_out, data_out, select);
            end
        end else begin
            checks++;
            assert (valid_out === (p != 4'b0000)) else begin
                errors++;
                $error("FAIL valid_latency observed=%b expected=%b", valid_out, (p != 4'b0000));
            end
            if (valid_out === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $error("FAIL data_unexpected observed=%h expected=none", data_out);
                end else begin
                    ed = exp_q.pop_front();
                    checks++;
                    assert (data_out === ed && select === ed[9:8]) else begin
                        errors++;
                        $error("FAIL data_out observed=%h/%b expected=%h/%b",
                               data_out, select, ed, ed[9:8]);
                    end
                    last_data = ed;
                end
            end else begin
                checks++;
                assert (data_out === last_data && select === last_data[9:8]) else begin
                    errors++;
                    $error("FAIL data_hold observed=%h expected=%h", data_out, last_data);
                end
            end
        end
        #1;
    endtask

    task automatic drain(input int max_ticks);
        int n;
        n = 0;
        while ((src_q.size() != 0 || exp_q.size() != 0) && n < max_ticks) begin
            tick();
            n++;
        end
        check_int("drain_src_left", src_q.size(), 0);
        check_int("drain_data_left", exp_q.size(), 0);
        for (int i = 0; i < 3; i++) tick();
    endtask

    initial begin
        reset           = 1'b0;
        out_almost_full = 1'b0;
        last_data       = 10'h000;
        last_p          = 4'b0000;
        for (int s = 0; s < 4; s++) fq[s].push_back(10'(s * 3 + 1));
        drive_ports();
        #2;

        // 1: reset held with all FIFOs non-empty.
        tick();
        check_int("rst_pop0", int'(last_p), 0);
        tick();
        check_int("rst_pop1", int'(last_p), 0);
        check_int("rst_grant", int'(grant_id), 0);
        for (int s = 0; s < 4; s++) fq[s].delete();
        drive_ports();
        reset = 1'b1;
        tick();
        check_int("idle_state", int'(dut.state), int'(IDLE));

        // 2: only FIFO1 holds three words.
        load(1, 10'h1A5); load(1, 10'h2B6); load(1, 10'h3C7);
        expect_w(1, 10'h1A5); expect_w(1, 10'h2B6); expect_w(1, 10'h3C7);
        for (int i = 0; i < 5; i++) tick();
        check_int("t2_state", int'(dut.state), int'(IDLE));
        check_int("t2_ptr", int'(dut.ptr), 2);
        check_int("t2_grant", int'(grant_id), 1);
        check_int("t2_left", exp_q.size(), 0);

        // 3: all four FIFOs hold 6 words, starting from ptr 0.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        for (int s = 0; s < 4; s++)
            for (int k = 0; k < 6; k++) load(s, 10'(s * 160 + k * 23 + 5));
        for (int r = 0; r < 2; r++)
            for (int s = 0; s < 4; s++)
                for (int k = r * 4; k < ((r == 0) ? 4 : 6); k++)
                    expect_w(s, 10'(s * 160 + k * 23 + 5));
        drain(80);
        check_int("t3_ptr", int'(dut.ptr), 0);

        // 4: backpressure after FIFO2's second pop.
        for (int k = 0; k < 4; k++) begin
            load(2, 10'(10'h200 + k * 17));
            expect_w(2, 10'(10'h200 + k * 17));
        end
        tick(); tick(); tick();
        check_int("t4_cnt_pre", int'(dut.cnt), 2);
        out_almost_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_int("t4_pause_pop", int'(last_p), 0);
            check_int("t4_pause_state", int'(dut.state), int'(PAUSE));
            check_int("t4_pause_grant", int'(grant_id), 2);
            check_int("t4_pause_cnt", int'(dut.cnt), 2);
        end
        out_almost_full = 1'b0;
        load(3, 10'h0F3);
        expect_w(3, 10'h0F3);
        drain(20);
        check_int("t4_ptr", int'(dut.ptr), 0);

        // 5: reset mid-burst on FIFO2 while FIFO0 waits.
        for (int k = 0; k < 4; k++) load(2, 10'(10'h281 + k * 9));
        expect_w(2, 10'h281); expect_w(2, 10'h28A);
        tick(); tick(); tick();
        check_int("t5_grant_pre", int'(grant_id), 2);
        check_int("t5_cnt_pre", int'(dut.cnt), 2);
        load(0, 10'h155);
        expect_w(0, 10'h155);
        expect_w(2, 10'h293); expect_w(2, 10'h29C);
        reset = 1'b0;
        tick();
        check_int("t5_rst_pop", int'(last_p), 0);
        check_int("t5_rst_state", int'(dut.state), int'(IDLE));
        check_int("t5_rst_ptr", int'(dut.ptr), 0);
        reset = 1'b1;
        tick();
        check_int("t5_post_pop", int'(last_p), 0);
        check_int("t5_post_grant", int'(grant_id), 0);
        drain(20);
        check_int("t5_ptr", int'(dut.ptr), 3);

        // 6: ptr=1 with only FIFO3 and FIFO0 holding one word each.
        load(0, 10'h0AA);
        expect_w(0, 10'h0AA);
        drain(10);
        check_int("t6_ptr_pre", int'(dut.ptr), 1);
        load(3, 10'h3E1); load(0, 10'h122);
        expect_w(3, 10'h3E1); expect_w(0, 10'h122);
        drain(20);
        check_int("t6_ptr", int'(dut.ptr), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_rr_scheduler
